rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
// PURPOSE
//  Parametrised N-port arbiter with fixed or round-robin priority and registered one-hot grant.
//  Holds a grant per a selectable blocking mode.
//  Drives the grant/grant_valid/grant_encoded/acknowledge contract used by the ethernet mux paths.
//  Serves as the sequential arbiter case in the abc9 flow regressions.
// PARAMETERS
//  PORTS         4   number of requesters, 2..32
//  ROUND_ROBIN   1   1: rotating priority; 0: fixed priority
//  BLOCK         2   0 NONE: re-arbitrate every cycle; 1 REQUEST: hold while request held; 2 ACKNOWLEDGE: hold until ack
//  LSB_PRIORITY  1   1: lower index wins ties/fixed order; 0: higher index wins
//  TIMEOUT       16  max held cycles before forced release (only with ARB_HOLD_TIMEOUT_EN), >=1
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            asynchronous, active-low reset
//  request        in   PORTS        per-port request level
//  acknowledge    in   PORTS        per-port release pulse (BLOCK=2 only; else ignored)
//  grant          out  PORTS        registered one-hot grant, zero when none
//  grant_valid    out  1            |grant
//  grant_encoded  out  max(1,clog2(PORTS))  index of granted port; 0 when none
//  timeout_pulse  out  1            1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk):
//   - grant=0, grant_valid=0, grant_encoded=0, timeout_pulse=0
//   - priority pointer=0 (port 0 highest when LSB_PRIORITY=1)
//  Latency: request high at edge k -> grant visible after edge k+1 (1 cycle); all outputs from flops.
//  States:
//   - IDLE (grant_valid=0): any request -> GRANT(winner); else stay
//   - GRANT(g) exit conditions:
//     - BLOCK=0: always re-arbitrate next edge
//     - BLOCK=1: release when request[g]=0
//     - BLOCK=2: release when acknowledge[g]=1 (request[g] drop alone does not release)
//   - Release re-arbitrates at the same edge: other requesters -> GRANT(new), no idle bubble; else -> IDLE.
//  Winner selection:
//   - ROUND_ROBIN=1: search starts at (g+1) mod PORTS after granting g; wraps PORTS-1 -> 0 (LSB_PRIORITY=0 mirrors)
//   - ROUND_ROBIN=0: lowest (or highest) index always wins; pointer unused
//   - Pointer updates only when a new grant is issued, not while holding.
//  Simultaneous events:
//   - ack on a non-granted port ignored
//   - ack[g] with request[g] still high: g is re-eligible but lowest priority under RR; under fixed priority g may win again
//   - requests arriving during a hold are queued only as levels (no memory)
//  grant_encoded == log2(grant) whenever grant_valid; grant is never multi-hot.
//  Async reset mid-hold drops grant immediately; no ack required afterwards.
// CONFIGURATION
//  ARB_HOLD_TIMEOUT_EN defined:
//   - hold counter clears on each new grant, increments each held cycle
//   - at TIMEOUT held cycles (BLOCK=1/2): grant released as if acked, timeout_pulse=1 for 1 cycle, pointer advances past g
//   - BLOCK=0: counter never fires
//  Not defined: no counter logic; timeout_pulse tied 0; holds are unbounded.
// TESTING (PORTS=4, ROUND_ROBIN=1, LSB_PRIORITY=1 unless noted)
//  1 Reset: rst_n=0 with request=4'b1111 -> grant=0, grant_valid=0, grant_encoded=0; rst_n=1 -> next edge grant=4'b0001
//  2 RR rotation, BLOCK=0, request=4'b1111 held -> grant 0001,0010,0100,1000,0001 on successive cycles, encoded 0,1,2,3,0
//  3 BLOCK=2: request=4'b0101 -> grant=0001; drop request[0], no ack -> grant stays 0001;
//    ack[2] -> ignored; ack[0] -> next grant=0100 with no idle cycle
//  4 BLOCK=1, ROUND_ROBIN=0: request=4'b1100, grant=0100; raise request[0] -> still 0100;
//    drop request[2] -> grant=0001
//  5 Wrap: last grant=1000, request=4'b1001 -> grant=0001; LSB_PRIORITY=0 with pointer 0 and request=4'b1001 -> grant=1000
//  6 ARB_HOLD_TIMEOUT_EN, BLOCK=2, TIMEOUT=16, request=4'b0011, never ack ->
//    after 16 held cycles timeout_pulse=1 for one cycle and grant=0010; without macro grant stays 0001 for 100 cycles

Source files
------------

// File: rtl/rr_grant_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter_if
//   Request/grant bundle between a set of requesters and rr_grant_arbiter.
//
//   Parameter
//     PORTS          number of requesters (2..32)
//
//   Signals
//     request        per-port request level            (requester -> arbiter)
//     acknowledge    per-port release pulse             (requester -> arbiter)
//     grant          registered one-hot grant           (arbiter -> requester)
//     grant_valid    |grant                             (arbiter -> requester)
//     grant_encoded  index of granted port, 0 if none   (arbiter -> requester)
//     timeout_pulse  1-cycle pulse on forced release    (arbiter -> requester)
//
//   Modports
//     master         requester side (drives request/acknowledge)
//     slave          arbiter side   (drives the grant outputs)
// ----------------------------------------------------------------------------
interface rr_grant_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int ENC_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [ENC_W-1:0] grant_encoded;
    logic             timeout_pulse;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded,
        input  timeout_pulse
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded,
        output timeout_pulse
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//   N-port arbiter with fixed or rotating priority and a registered one-hot
//   grant. A grant is held according to BLOCK:
//     0 NONE        re-arbitrate on every edge
//     1 REQUEST     hold while the granted request stays high
//     2 ACKNOWLEDGE hold until the granted port pulses acknowledge
//   A release re-arbitrates on the same edge, so there is no idle bubble
//   between back-to-back grants. All outputs come straight from flops.
//
//   Optional feature (macro ARB_HOLD_TIMEOUT_EN):
//     a hold counter forces a release after TIMEOUT held cycles (BLOCK=1/2)
//     and raises timeout_pulse for one cycle. Without the macro there is no
//     counter, holds are unbounded and timeout_pulse is tied low.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rr_grant_arbiter_if.slave (request/acknowledge in, grant out)
// ----------------------------------------------------------------------------
module rr_grant_arbiter #(
    parameter int PORTS        = 4,
    parameter int ROUND_ROBIN  = 1,
    parameter int BLOCK        = 2,
    parameter int LSB_PRIORITY = 1,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int               PTR_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PORTS - 1);
    localparam logic [PTR_W:0]   PORTS_W  = (PTR_W + 1)'(PORTS);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] enc_q,   enc_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;

    // ------------------------------------------------------------------
    // Winner search. The pointer and the search live in a "mirrored" index
    // space when LSB_PRIORITY=0, so one upward search serves both orders.
    // ------------------------------------------------------------------
    logic [PORTS-1:0] req_m, req_rot;
    logic [PTR_W-1:0] start, off, win_m, win_idx, win_next;
    logic [PTR_W:0]   sum;
    logic             any_req;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            req_m[i] = (LSB_PRIORITY != 0) ? bus.request[i] : bus.request[PORTS-1-i];
        end
    end

    assign any_req = |bus.request;
    assign start   = (ROUND_ROBIN != 0) ? ptr_q : '0;
    // Rotate so the highest-priority port sits at bit 0.
    assign req_rot = PORTS'({req_m, req_m} >> start);

    always_comb begin
        off = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) off = PTR_W'(i);
        end
    end

    always_comb begin
        sum      = {1'b0, start} + {1'b0, off};
        win_m    = (sum >= PORTS_W) ? PTR_W'(sum - PORTS_W) : sum[PTR_W-1:0];
        win_idx  = (LSB_PRIORITY != 0) ? win_m : PTR_LAST - win_m;
        // The winner becomes lowest priority for the next search.
        win_next = (win_m == PTR_LAST) ? '0 : win_m + PTR_W'(1);
    end

    // ------------------------------------------------------------------
    // Release conditions for the current grant.
    // ------------------------------------------------------------------
    logic normal_release;
    logic timeout_fire;
    logic hold;
    logic pulse_out;

    always_comb begin
        case (BLOCK)
            1:       normal_release = ~bus.request[enc_q];
            2:       normal_release = bus.acknowledge[enc_q];
            default: normal_release = 1'b1;
        endcase
    end

    assign hold = (state_q == S_GRANT) && !normal_release && !timeout_fire;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Counts held edges since the grant was issued; reaching CNT_LAST means
    // the grant has been visible for TIMEOUT cycles.
    logic [CNT_W-1:0] hold_cnt_q;
    logic             pulse_q;

    assign timeout_fire = (BLOCK != 0) && (state_q == S_GRANT) &&
                          !normal_release && (hold_cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            hold_cnt_q <= hold ? hold_cnt_q + CNT_W'(1) : '0;
            pulse_q    <= timeout_fire;
        end
    end

    assign pulse_out = pulse_q;
`else
    assign timeout_fire = 1'b0;
    assign pulse_out    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every control flop gets a reset value; there is no storage
        // array here that could be left unreset.
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational blocks.
            state_q <= state_d;
            grant_q <= grant_d;
            enc_q   <= enc_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A release and a fresh grant happen on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        enc_d   = enc_q;
        ptr_d   = ptr_q;
        if (!hold) begin
            if (any_req) begin
                state_d          = S_GRANT;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                enc_d            = win_idx;
                ptr_d            = win_next;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                enc_d   = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, taken directly from registered state.
    // ------------------------------------------------------------------
    always_comb begin
        bus.grant         = grant_q;
        bus.grant_valid   = (state_q == S_GRANT);
        bus.grant_encoded = enc_q;
        bus.timeout_pulse = pulse_out;
    end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_arbiter
//   Four arbiter instances (PORTS=4) side by side:
//     u0 BLOCK=0 RR  LSB      u1 BLOCK=1 fixed LSB
//     u2 BLOCK=2 RR  LSB      u3 BLOCK=0 RR  MSB
//   A behavioural model (priority list search on plain integers) predicts
//   every output of every instance after each clock edge; directed steps
//   add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_rr_grant_arbiter;
    localparam int P   = 4;
    localparam int NI  = 4;
    localparam int TMO = 16;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    function automatic int cfg_block(int i);
        case (i)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_rr(int i);  return (i == 1) ? 0 : 1; endfunction
    function automatic int cfg_lsb(int i); return (i == 3) ? 0 : 1; endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [P-1:0] req_v  [NI];
    logic [P-1:0] ack_v  [NI];
    logic [P-1:0] g_out  [NI];
    logic         gv_out [NI];
    logic [1:0]   enc_out[NI];
    logic         tp_out [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        rr_grant_arbiter_if #(.PORTS(P)) bus ();
        assign bus.request     = req_v[gi];
        assign bus.acknowledge = ack_v[gi];
        assign g_out[gi]       = bus.grant;
        assign gv_out[gi]      = bus.grant_valid;
        assign enc_out[gi]     = bus.grant_encoded;
        assign tp_out[gi]      = bus.timeout_pulse;

        rr_grant_arbiter #(
            .PORTS        (P),
            .ROUND_ROBIN  (cfg_rr(gi)),
            .BLOCK        (cfg_block(gi)),
            .LSB_PRIORITY (cfg_lsb(gi)),
            .TIMEOUT      (TMO)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // ---------------- reference model ----------------
    bit m_valid[NI];
    int m_g    [NI];
    int m_start[NI];   // first port examined by the next round-robin search
    int m_held [NI];   // cycles the current grant has been visible
    bit m_pulse[NI];

    int vectors     = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_valid[i] = 1'b0;
            m_g[i]     = 0;
            m_start[i] = (cfg_lsb(i) != 0) ? 0 : P - 1;
            m_held[i]  = 0;
            m_pulse[i] = 1'b0;
        end
    endtask

    // Walk the priority list from 'start' (upward for LSB, downward for MSB).
    function automatic int pick(int i, logic [P-1:0] rq, int start);
        for (int k = 0; k < P; k++) begin
            int idx;
            idx = (cfg_lsb(i) != 0) ? (start + k) % P : (start - k + P) % P;
            if (rq[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            bit rel;
            bit forced;
            int st;
            int w;
            rel    = 1'b1;
            forced = 1'b0;
            if (m_valid[i]) begin
                case (cfg_block(i))
                    1:       rel = !req_v[i][m_g[i]];
                    2:       rel = ack_v[i][m_g[i]];
                    default: rel = 1'b1;
                endcase
                if (TMO_EN && cfg_block(i) != 0 && !rel && m_held[i] >= TMO) forced = 1'b1;
            end
            m_pulse[i] = forced;
            if (rel || forced) begin
                st = (cfg_rr(i) != 0) ? m_start[i] : ((cfg_lsb(i) != 0) ? 0 : P - 1);
                w  = pick(i, req_v[i], st);
                if (w >= 0) begin
                    m_valid[i] = 1'b1;
                    m_g[i]     = w;
                    m_held[i]  = 1;
                    m_start[i] = (cfg_lsb(i) != 0) ? (w + 1) % P : (w + P - 1) % P;
                end else begin
                    m_valid[i] = 1'b0;
                    m_held[i]  = 0;
                end
            end else begin
                m_held[i]++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_u%0d_grant", tag, i), 32'(g_out[i]),
                  m_valid[i] ? (32'd1 << m_g[i]) : 32'd0);
            check($sformatf("%s_u%0d_valid", tag, i), 32'(gv_out[i]), 32'(m_valid[i]));
            check($sformatf("%s_u%0d_enc", tag, i), 32'(enc_out[i]),
                  m_valid[i] ? 32'(m_g[i]) : 32'd0);
            check($sformatf("%s_u%0d_tmo", tag, i), 32'(tp_out[i]), 32'(m_pulse[i]));
        end
    endtask

    // Inputs are already set; predict the edge, take it, compare just after.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    logic [3:0] t2_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_v[i] = '0;
            ack_v[i] = '0;
        end
        model_reset();

        // 1: reset holds all outputs low even with every request raised.
        req_v[0] = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(g_out[0]), 32'd0);
        check("rst_valid", 32'(gv_out[0]), 32'd0);
        check("rst_enc",   32'(enc_out[0]), 32'd0);
        rst_n = 1'b1;
        step("t1");
        check("t1_grant", 32'(g_out[0]), 32'b0001);

        // 2: BLOCK=0 rotation with all requests held.
        for (int k = 0; k < 4; k++) begin
            step("t2");
            check("t2_grant", 32'(g_out[0]), 32'(t2_exp[k]));
            check("t2_enc",   32'(enc_out[0]), 32'((k + 1) % P));
        end
        req_v[0] = '0;
        step("t2_idle");

        // 3: BLOCK=2 hold until ack of the granted port.
        req_v[2] = 4'b0101;
        step("t3a");
        check("t3_first", 32'(g_out[2]), 32'b0001);
        req_v[2] = 4'b0100;
        step("t3b");
        check("t3_hold_noack", 32'(g_out[2]), 32'b0001);
        ack_v[2] = 4'b0100;
        step("t3c");
        check("t3_foreign_ack", 32'(g_out[2]), 32'b0001);
        ack_v[2] = 4'b0001;
        step("t3d");
        check("t3_handover", 32'(g_out[2]), 32'b0100);
        check("t3_handover_v", 32'(gv_out[2]), 32'd1);

        // 5a: wrap from port 3 back to port 0.
        req_v[2] = 4'b1001;
        ack_v[2] = 4'b0100;
        step("t5a");
        check("t5_last3", 32'(g_out[2]), 32'b1000);
        ack_v[2] = 4'b1000;
        step("t5b");
        check("t5_wrap", 32'(g_out[2]), 32'b0001);
        req_v[2] = '0;
        ack_v[2] = 4'b0001;
        step("t5c");
        ack_v[2] = '0;
        check("t5_idle", 32'(gv_out[2]), 32'd0);

        // 4: BLOCK=1 fixed priority.
        req_v[1] = 4'b1100;
        step("t4a");
        check("t4_first", 32'(g_out[1]), 32'b0100);
        req_v[1] = 4'b1101;
        step("t4b");
        check("t4_hold", 32'(g_out[1]), 32'b0100);
        req_v[1] = 4'b1001;
        step("t4c");
        check("t4_release", 32'(g_out[1]), 32'b0001);
        req_v[1] = '0;
        step("t4_idle");

        // 5b: MSB priority with pointer at reset value.
        req_v[3] = 4'b1001;
        step("t5d");
        check("t5_msb", 32'(g_out[3]), 32'b1000);
        req_v[3] = '0;
        step("t5_msb_idle");

        // 6: hold without ack, with and without the timeout feature.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_v[2] = 4'b0011;
        step("t6a");
        check("t6_first", 32'(g_out[2]), 32'b0001);
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int k = 1; k < TMO; k++) begin
            step("t6_hold");
            check("t6_hold_grant", 32'(g_out[2]), 32'b0001);
        end
        step("t6_fire");
        check("t6_tmo_grant", 32'(g_out[2]), 32'b0010);
        check("t6_tmo_pulse", 32'(tp_out[2]), 32'd1);
        step("t6_after");
        check("t6_pulse_once", 32'(tp_out[2]), 32'd0);
`else
        for (int k = 0; k < 100; k++) step("t6_hold");
        check("t6_unbounded", 32'(g_out[2]), 32'b0001);
        check("t6_no_pulse", 32'(tp_out[2]), 32'd0);
`endif

        // Async reset mid-hold drops the grant without waiting for an edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(g_out[2]), 32'd0);
        check("arst_valid", 32'(gv_out[2]), 32'd0);
        model_reset();
        req_v[2] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("arst_idle");
        req_v[2] = 4'b0100;
        step("arst_regrant");
        check("arst_no_ack_needed", 32'(g_out[2]), 32'b0100);
        ack_v[2] = 4'b0100;
        req_v[2] = '0;
        step("arst_release");
        ack_v[2] = '0;

        // Randomized traffic: sticky requests, sparse acks.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NI; i++) begin
                req_v[i] = req_v[i] ^ (4'($urandom) & 4'($urandom));
                ack_v[i] = 4'($urandom) & 4'($urandom) & 4'($urandom);
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
